// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared types for the nonce scheduler: FSM states, job record, nonce width
// and the difficulty saturation helper.
package sha_sched_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [255:0] midstate;
    logic [95:0]  tail;
    logic [31:0]  difficulty;
  } job_t;

  // A prefix longer than the hash is the whole hash.
  function automatic logic [8:0] sat_difficulty(input logic [31:0] d);
    if (d > 32'd256) begin
      return 9'd256;
    end else begin
      return d[8:0];
    end
  endfunction

endpackage

// File: rtl/sha_nonce_scheduler_lzc.sv
// Combinational test that the top D bits of a 256-bit double hash are zero,
// with D saturated at 256 (D=0 always passes).
module sha_leading_zero_check
  import sha_sched_pkg::*;
(
  input  logic [255:0] hash,
  input  logic [31:0]  difficulty,
  output logic         hit
);

  logic [8:0]   d;
  logic [255:0] mask;

  // Build a mask covering the D most significant bits and test them.
  always_comb begin
    d    = sat_difficulty(difficulty);
    mask = ~({256{1'b1}} >> d);
    hit  = ((hash & mask) == 256'd0);
  end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Per-core job sequencer: issues one nonce per cycle into the double-SHA256
// core, retires results in order and reports hashes meeting the difficulty.
module sha_nonce_scheduler
  import sha_sched_pkg::*;
#(
  parameter logic [31:0] PROCESSORINDEX = 32'd0,
  parameter int unsigned NUMPROCESSORS  = 32'd1,
  parameter int unsigned PIPE_LATENCY   = 32'd131,
  parameter bit          STOP_ON_FIND   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [31:0]  job_difficulty,
  input  logic         abort,
  output logic         core_valid,
  output logic         core_newblock,
  output logic [255:0] core_hashstate,
  output logic [127:0] core_w,
  output logic [31:0]  core_difficulty,
  input  logic         res_valid,
  input  logic [255:0] res_hash,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(PIPE_LATENCY + 32'd1);
  localparam logic [NONCE_W-1:0] STRIDE = NONCE_W'(NUMPROCESSORS);

  state_t               state_r;
  job_t                 job_r;
  logic [NONCE_W-1:0]   nonce_r;
  logic [NONCE_W-1:0]   retire_nonce_r;
  logic [CW-1:0]        inflight_r;
  logic [CW-1:0]        inflight_next;
  logic [NONCE_W:0]     issue_sum;
  logic                 retire;
  logic                 hit;

  assign core_hashstate  = job_r.midstate;
  assign core_difficulty = job_r.difficulty;
  assign core_w          = {job_r.tail, nonce_r};

  sha_leading_zero_check u_lzc (
    .hash       (res_hash),
    .difficulty (job_r.difficulty),
    .hit        (hit)
  );

  // Next nonce (carry marks the last one) and in-flight bookkeeping.
  always_comb begin
    issue_sum = {1'b0, nonce_r} + {1'b0, STRIDE};
    retire    = res_valid && (inflight_r != '0);
    if (core_valid && !retire) begin
      inflight_next = inflight_r + CW'(1'b1);
    end else if (!core_valid && retire) begin
      inflight_next = inflight_r - CW'(1'b1);
    end else begin
      inflight_next = inflight_r;
    end
  end

  // Job FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      job_r          <= '0;
      nonce_r        <= '0;
      retire_nonce_r <= '0;
      inflight_r     <= '0;
      job_ready      <= 1'b0;
      core_valid     <= 1'b0;
      core_newblock  <= 1'b0;
      found_valid    <= 1'b0;
      found_nonce    <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      core_newblock <= 1'b0;
      found_valid   <= 1'b0;
      done          <= 1'b0;
      inflight_r    <= inflight_next;
      if (res_valid && (inflight_r == '0)) begin
        err <= 1'b1;
      end
      if (retire) begin
        retire_nonce_r <= retire_nonce_r + STRIDE;
      end
      case (state_r)
        IDLE: begin
          if (job_valid && job_ready) begin
            job_r          <= '{midstate: job_midstate, tail: job_tail,
                                difficulty: job_difficulty};
            nonce_r        <= PROCESSORINDEX;
            retire_nonce_r <= PROCESSORINDEX;
            state_r        <= RUN;
            job_ready      <= 1'b0;
            core_valid     <= 1'b1;
            core_newblock  <= 1'b1;
            busy           <= 1'b1;
          end else begin
            job_ready <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state_r    <= FLUSH;
            core_valid <= 1'b0;
          end else if (retire && hit && STOP_ON_FIND) begin
            found_valid <= 1'b1;
            found_nonce <= retire_nonce_r;
            state_r     <= FLUSH;
            core_valid  <= 1'b0;
          end else begin
            if (retire && hit) begin
              found_valid <= 1'b1;
              found_nonce <= retire_nonce_r;
            end
            if (state_r == RUN) begin
              if (issue_sum[NONCE_W]) begin
                state_r    <= DRAIN;
                core_valid <= 1'b0;
              end else begin
                nonce_r <= issue_sum[NONCE_W-1:0];
              end
            end else if (inflight_next == '0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (inflight_next == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          core_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench: four scheduler configurations, each fed by a 4-cycle core
// model whose hash top word is nonce^hkey, so hits are placed by choice of hkey.
module tb_sha_nonce_scheduler;

  localparam logic [31:0] PI_T  [4] = '{32'd0, 32'd0, 32'd3, 32'hFFFF_FFF0};
  localparam int          NP_T  [4] = '{1, 1, 4, 1};
  localparam bit          SOF_T [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] midstate, ms_saved;
  logic [95:0]  tail;
  logic [31:0]  diff, hkey;
  logic         hlsb;

  logic         job_valid [4], abort [4], job_ready [4], core_valid [4];
  logic         core_newblock [4], res_valid [4], found_valid [4];
  logic         done [4], busy [4], err [4];
  logic [255:0] core_hashstate [4], res_hash [4];
  logic [127:0] core_w [4];
  logic [31:0]  core_difficulty [4], found_nonce [4];
  logic [256:0] pipe [4][4];

  int checks = 0, errors = 0;
  int found_cnt [4], done_cnt [4], issue_cnt [4], res_cnt [4];
  logic [31:0] last_issue [4];
  int cyc, f0, d0, i0, r0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha_nonce_scheduler #(
      .PROCESSORINDEX (PI_T[g]),
      .NUMPROCESSORS  (NP_T[g]),
      .PIPE_LATENCY   (4),
      .STOP_ON_FIND   (SOF_T[g])
    ) u_dut (
      .clk (clk), .rst (rst),
      .job_valid (job_valid[g]), .job_ready (job_ready[g]),
      .job_midstate (midstate), .job_tail (tail), .job_difficulty (diff),
      .abort (abort[g]),
      .core_valid (core_valid[g]), .core_newblock (core_newblock[g]),
      .core_hashstate (core_hashstate[g]), .core_w (core_w[g]),
      .core_difficulty (core_difficulty[g]),
      .res_valid (res_valid[g]), .res_hash (res_hash[g]),
      .found_valid (found_valid[g]), .found_nonce (found_nonce[g]),
      .done (done[g]), .busy (busy[g]), .err (err[g])
    );
  end

  // Core model: fixed 4-cycle delay, not reset so stale results survive rst.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pipe[k][0] <= {core_valid[k], core_w[k][31:0] ^ hkey, 223'd0, hlsb};
      for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      res_valid[k] = pipe[k][3][256];
      res_hash[k]  = pipe[k][3][255:0];
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (found_valid[m] === 1'b1) found_cnt[m] <= found_cnt[m] + 1;
      if (done[m] === 1'b1)        done_cnt[m]  <= done_cnt[m] + 1;
      if (res_valid[m] === 1'b1)   res_cnt[m]   <= res_cnt[m] + 1;
      if (core_valid[m] === 1'b1) begin
        issue_cnt[m]  <= issue_cnt[m] + 1;
        last_issue[m] <= core_w[m][31:0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns positioned in the first issue cycle of the new job.
  task automatic start_job(input int k, input logic [31:0] d);
    int n = 0;
    diff = d;
    while (job_ready[k] !== 1'b1 && n < 2000) begin step(1); n++; end
    check("job_ready", job_ready[k], 1'b1);
    job_valid[k] = 1'b1;
    step(1);
    job_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int limit, output int c);
    c = 0;
    while (done[k] !== 1'b1 && c < limit) begin step(1); c++; end
    check("done_seen", done[k], 1'b1);
  endtask

  task automatic wait_found(input int k, input int limit, output int c);
    c = 0;
    while (found_valid[k] !== 1'b1 && c < limit) begin step(1); c++; end
    check("found_seen", found_valid[k], 1'b1);
  endtask

  initial begin
    rst = 1'b1; hkey = 32'd0; hlsb = 1'b1; diff = 32'd0;
    midstate = {8{32'h6A09_E667}} ^ 256'h0123_4567_89AB_CDEF;
    tail = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
    for (int k = 0; k < 4; k++) begin job_valid[k] = 1'b0; abort[k] = 1'b0; end
    step(5);
    check("rst_job_ready", job_ready[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_core_w", core_w[0][63:0], 64'd0);
    rst = 1'b0;
    step(1);
    check("ready_after_rst", job_ready[0], 1'b1);

    // Difficulty 0, stop on find: only nonce 0 reported, then flush.
    f0 = found_cnt[0]; i0 = issue_cnt[0];
    start_job(0, 32'd0);
    check("t1_valid", core_valid[0], 1'b1);
    check("t1_newblock", core_newblock[0], 1'b1);
    check("t1_nonce0", core_w[0][31:0], 32'd0);
    check("t1_tail", core_w[0][127:64], tail[95:32]);
    check("t1_hashstate", core_hashstate[0] == midstate, 1'b1);
    check("t1_busy", busy[0], 1'b1);
    step(1);
    check("t1_newblock_low", core_newblock[0], 1'b0);
    check("t1_nonce1", core_w[0][31:0], 32'd1);
    step(4);
    check("t1_found", found_valid[0], 1'b1);
    check("t1_found_nonce", found_nonce[0], 32'd0);
    check("t1_stop_issue", core_valid[0], 1'b0);
    step(1);
    check("t1_found_pulse", found_valid[0], 1'b0);
    wait_done(0, 50, cyc);
    check("t1_done_lat", cyc, 3);
    check("t1_busy_low", busy[0], 1'b0);
    check("t1_ready_low", job_ready[0], 1'b0);
    check("t1_found_cnt", found_cnt[0] - f0, 1);
    check("t1_issue_cnt", issue_cnt[0] - i0, 5);
    step(1);
    check("t1_ready_rise", job_ready[0], 1'b1);

    // Difficulty 300 saturates to 256: bit 0 alone is a miss, all-zero is a hit.
    f0 = found_cnt[0];
    start_job(0, 32'd300);
    check("t5_difficulty", core_difficulty[0], 32'd300);
    step(5);
    check("t5_bit0_miss", found_valid[0], 1'b0);
    abort[0] = 1'b1; step(1); abort[0] = 1'b0;
    wait_done(0, 50, cyc);
    check("t5_no_hits", found_cnt[0] - f0, 0);
    hlsb = 1'b0;
    start_job(0, 32'd300);
    step(5);
    check("t5_zero_hit", found_valid[0], 1'b1);
    check("t5_zero_nonce", found_nonce[0], 32'd0);
    wait_done(0, 50, cyc);
    hlsb = 1'b1;

    // Difficulty 0, sweep mode: a hit every cycle, then abort.
    start_job(1, 32'd0);
    step(5);
    for (int i = 0; i < 6; i++) begin
      check("t2_found", found_valid[1], 1'b1);
      check("t2_found_nonce", found_nonce[1], 32'(i));
      step(1);
    end
    abort[1] = 1'b1; step(1); abort[1] = 1'b0;
    f0 = found_cnt[1];
    check("t2_abort_issue", core_valid[1], 1'b0);
    check("t2_abort_nofind", found_valid[1], 1'b0);
    wait_done(1, 50, cyc);
    check("t2_done_lat", cyc, 4);
    check("t2_no_find_after", found_cnt[1] - f0, 0);
    hkey = 32'hFFFF_0000;
    start_job(1, 32'd32);
    check("t2_next_newblock", core_newblock[1], 1'b1);
    check("t2_next_nonce", core_w[1][31:0], 32'd0);
    abort[1] = 1'b1; step(1); abort[1] = 1'b0;
    wait_done(1, 50, cyc);

    // Known answer: stride 4 from 3, golden nonce at issue 1000.
    hkey = 32'd4003;
    start_job(2, 32'd32);
    ms_saved = midstate;
    midstate = ~midstate;
    check("t3_first_nonce", core_w[2][31:0], 32'd3);
    wait_found(2, 3000, cyc);
    check("t3_found_lat", cyc, 1005);
    check("t3_golden", found_nonce[2], 32'd4003);
    check("t3_hold_state", core_hashstate[2] == ms_saved, 1'b1);
    check("t3_hold_diff", core_difficulty[2], 32'd32);
    wait_done(2, 50, cyc);
    check("t3_done_lat", cyc, 4);
    midstate = ms_saved;

    // End of nonce range: FFFFFFFF issued once, one done, issues == retires.
    hkey = 32'd0;
    f0 = found_cnt[3]; d0 = done_cnt[3]; i0 = issue_cnt[3]; r0 = res_cnt[3];
    start_job(3, 32'd32);
    check("t4_first_nonce", core_w[3][31:0], 32'hFFFF_FFF0);
    wait_done(3, 100, cyc);
    check("t4_done_lat", cyc, 20);
    step(4);
    check("t4_last_nonce", last_issue[3], 32'hFFFF_FFFF);
    check("t4_issues", issue_cnt[3] - i0, 16);
    check("t4_retires", res_cnt[3] - r0, 16);
    check("t4_one_done", done_cnt[3] - d0, 1);
    check("t4_no_hits", found_cnt[3] - f0, 0);
    for (int k = 0; k < 4; k++) check("err_clear", err[k], 1'b0);

    // Reset mid-RUN with three results in flight.
    hkey = 32'd0;
    f0 = found_cnt[0];
    start_job(0, 32'd0);
    step(3);
    rst = 1'b1;
    #1;
    check("t6_valid_low", core_valid[0], 1'b0);
    check("t6_busy_low", busy[0], 1'b0);
    check("t6_w_low", core_w[0][63:0], 64'd0);
    check("t6_diff_low", core_difficulty[0], 32'd0);
    step(1);
    rst = 1'b0;
    step(5);
    check("t6_err", err[0], 1'b1);
    check("t6_no_found", found_cnt[0] - f0, 0);
    check("t6_idle", busy[0], 1'b0);
    check("t6_ready", job_ready[0], 1'b1);
    check("t6_err_other", err[2], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
Name: sha_nonce_scheduler

Overview:
- Controller that sequences the double-SHA256 pipelined last core for one mining job.
- Accepts a job (first-block midstate, three tail words, difficulty) and issues one nonce per cycle into the core.
- Tracks in-flight work, retires results in order, tests each double hash against the difficulty, and reports winning nonces.
- Sits between the job distributor and one core instance; one scheduler per core.

Parameters:
PROCESSORINDEX, 0, first nonce issued; nonce residue owned by this core
NUMPROCESSORS, 1, nonce stride; range 1..256
PIPE_LATENCY, 131, cycles from core_valid to the matching res_valid; range 1..1023
STOP_ON_FIND, 1, 1: end the job at the first hit; 0: sweep the full nonce range

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
job_valid  in  1  job offered
job_ready  out  1  job accepted when job_valid and job_ready are both high
job_midstate  in  256  HashState after the first 64-byte block, {a..h}
job_tail  in  96  {w0,w1,w2}, the message words preceding the nonce
job_difficulty  in  32  required leading zero bits of the double hash; values above 256 are treated as 256
abort  in  1  cancel the current job
core_valid  out  1  issue strobe to the core
core_newblock  out  1  high with the first issue of each job
core_hashstate  out  256  job midstate, held for the whole job
core_w  out  128  {w0,w1,w2,nonce}
core_difficulty  out  32  job difficulty, held for the whole job
res_valid  in  1  core output_valid
res_hash  in  256  core doublehash, bit 255 is the MSB
found_valid  out  1  one-cycle pulse: hit found
found_nonce  out  32  nonce of the hit; valid while found_valid is high
done  out  1  one-cycle pulse: job finished and pipeline empty
busy  out  1  high in any state other than IDLE
err  out  1  sticky: res_valid arrived with no work in flight

Behaviour:
- Reset (asynchronous) gives state IDLE and drives every output low.
  - Includes core_valid, found_valid, done, busy, err, job_ready, and all data outputs to zero.
- States are IDLE, RUN, DRAIN, FLUSH.
- IDLE:
  - job_ready=1.
  - On accept: latch the job, set issue_nonce=PROCESSORINDEX, set retire_nonce=PROCESSORINDEX, go to RUN.
- RUN:
  - core_valid=1 every cycle and core_w nonce=issue_nonce.
  - core_newblock=1 only on the first RUN cycle of the job.
  - issue_nonce advances by NUMPROCESSORS each cycle using a 33-bit add.
  - The first issue occurs on the cycle after accept.
- Last issue:
  - When the add carries, the current nonce is the last one; go to DRAIN after issuing it.
  - Nonce FFFFFFFF is issued exactly once when it belongs to this core.
- In-flight counter:
  - +1 on each issue, -1 on each res_valid; both in the same cycle leaves it unchanged.
  - The counter never exceeds PIPE_LATENCY.
- Retire:
  - On res_valid, hit = res_hash[255 -: D] == 0, where D = min(job_difficulty,256).
  - D=0 means every result is a hit.
  - retire_nonce advances by NUMPROCESSORS on every retire; results are in order.
- Hit handling:
  - A hit pulses found_valid with found_nonce=retire_nonce on the cycle after the res_valid (registered).
  - With STOP_ON_FIND=1, a hit in RUN or DRAIN stops issuing and goes to FLUSH.
- DRAIN:
  - No issue; results continue to be retired and checked.
  - When the in-flight counter reaches 0, pulse done and go to IDLE.
- FLUSH:
  - No issue; results are discarded with no hit checks.
  - When the in-flight counter reaches 0, pulse done and go to IDLE.
- abort:
  - In RUN or DRAIN, abort moves to FLUSH on the next cycle.
  - In IDLE or FLUSH, abort is ignored.
  - abort takes priority over a same-cycle hit: no found_valid for that result.
- Unexpected result: res_valid with the in-flight counter at 0 sets err, is otherwise ignored, and the counter stays at 0.
- Pipeline gaps: no gaps are ever issued within a job, so the in-order nonce reconstruction is exact.
- Back-to-back jobs: job_ready rises in the cycle after the done pulse.
- Job fields during a job: core_hashstate, core_difficulty and the w0..w2 fields hold constant from accept to done.

Decomposition:
- Package sha_sched_pkg holds:
  - the state enum;
  - a job_t struct {midstate, tail, difficulty};
  - the NONCE_W=32 constant.
- Sub-module sha_leading_zero_check: combinational D-bit prefix-zero test of a 256-bit hash, with difficulty saturation at 256.

Test Plan:
- NUMPROCESSORS=1, PIPE_LATENCY=4, difficulty=0, model core as a 4-cycle delay:
  - found_valid every cycle after latency with found_nonce=0,1,2…;
  - with STOP_ON_FIND=1, only nonce 0 is reported, then done after the flush empties.
- PROCESSORINDEX=3, NUMPROCESSORS=4, known-answer job with difficulty 32 and the golden nonce at issue 1000:
  - found_nonce equals the golden value;
  - done arrives PIPE_LATENCY cycles later.
- Start nonce near the end of the range (test hook), STOP_ON_FIND=0, no hits:
  - last issued nonce is FFFFFFFF;
  - exactly one done pulse;
  - total issues equal total retires.
- abort asserted 10 cycles into RUN:
  - core_valid drops the next cycle;
  - no found_valid afterward;
  - done pulses when the in-flight counter reaches 0;
  - the next job shows core_newblock=1 on its first issue.
- Assert rst for one cycle mid-RUN with 3 results in flight:
  - all outputs go to 0 immediately (asynchronous);
  - the 3 stale res_valid pulses set err and are not reported.
- difficulty=300:
  - treated as 256;
  - an all-zero res_hash is a hit;
  - a hash with only bit 0 set is not.
